load_store_unit: RTL and testbench

- Responder side of the memory controls the decoder issues: MemWrite, load request, Store[1:0] and Load[2:0].
- Converts each datapath load/store into one word-aligned data-bus transaction using a req/ready handshake with byte strobes.
- Stalls the single-cycle core until the transaction completes.
- Sign- or zero-extends load data before result selection.
- Sits between the datapath ALU result / rs2 and the data memory.

---
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one datapath load/store into a single word-aligned req/ready bus
// transaction, stalling the core until it completes. Optional macro: MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  store,
    input  logic [2:0]  load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        ld_r;
    logic [1:0]        alo_r;

    logic              acc_s;
    logic              is_st_s;
    logic              is_half_s;
    logic              is_word_s;
    logic              mis_s;
    logic              mis_trap_s;
    logic              timeout_s;
    logic              accept_s;
    logic [1:0]        alo_s;
    logic [3:0]        strb_s;
    logic [31:0]       wdat_s;

    // Select the addressed lane of the read word and sign/zero-extend it.
    function automatic logic [31:0] extend_load(input logic [2:0] ld, input logic [1:0] lo,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        case (ld)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'd0, b};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = d;
        endcase
    endfunction

    assign acc_s   = mem_write | mem_read;
    assign is_st_s = mem_write;

    // Decode access size; a simultaneous write wins over the read.
    always_comb begin
        is_half_s = 1'b0;
        is_word_s = 1'b0;
        if (mem_write) begin
            case (store)
                2'b00:   is_half_s = 1'b0;
                2'b01:   is_half_s = 1'b1;
                default: is_word_s = 1'b1;
            endcase
        end else begin
            case (load)
                3'b000, 3'b100: is_half_s = 1'b0;
                3'b001, 3'b101: is_half_s = 1'b1;
                default:        is_word_s = 1'b1;
            endcase
        end
    end

    assign mis_s = (is_half_s & addr[0]) | (is_word_s & (addr[1:0] != 2'b00));

`ifdef MISALIGN_TRAP_EN
    assign mis_trap_s = acc_s & mis_s;
`else
    assign mis_trap_s = 1'b0;
`endif

    // Aligned lane offset, strobes and lane-replicated store data.
    always_comb begin
        alo_s  = addr[1:0];
        strb_s = 4'b1111;
        wdat_s = wdata;
        if (is_word_s) begin
            alo_s = 2'b00;
        end else if (is_half_s) begin
            alo_s = {addr[1], 1'b0};
        end else begin
            alo_s = addr[1:0];
        end
        if (!is_st_s || is_word_s) begin
            strb_s = 4'b1111;
            wdat_s = wdata;
        end else if (is_half_s) begin
            strb_s = 4'b0011 << alo_s;
            wdat_s = {2{wdata[15:0]}};
        end else begin
            strb_s = 4'b0001 << alo_s;
            wdat_s = {4{wdata[7:0]}};
        end
    end

    assign timeout_s = (state_r == S_REQ) && !mem_ready &&
                       (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign accept_s  = (state_r == S_IDLE) && acc_s && !mis_trap_s;

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (acc_s) begin
                    state_nxt_s = mis_trap_s ? S_DONE : S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ready || timeout_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Stall must assert in the same cycle the access appears, hence combinational.
    assign stall = reset_n & (((state_r == S_IDLE) & acc_s) | (state_r == S_REQ));

    // State register and REQ-cycle timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= (state_r == S_REQ) ? cnt_r + CNT_W'(1) : '0;
        end
    end

    // Registered bus outputs, load result and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
            ld_r      <= 3'd0;
            alo_r     <= 2'd0;
        end else begin
            mem_req  <= (state_nxt_s == S_REQ);
            misalign <= (state_r == S_IDLE) & mis_trap_s;
            bus_err  <= timeout_s;
            if (accept_s) begin
                mem_addr  <= {addr[31:2], 2'b00};
                mem_we    <= is_st_s;
                mem_wstrb <= strb_s;
                mem_wdata <= wdat_s;
                ld_r      <= load;
                alo_r     <= alo_s;
            end else if (state_nxt_s != S_REQ) begin
                mem_we <= 1'b0;
            end else begin
                mem_we <= mem_we;
            end
            // mem_we is still held during REQ, so it identifies a store here
            if ((state_r == S_REQ) && mem_ready) begin
                rdata <= mem_we ? rdata : extend_load(ld_r, alo_r, mem_rdata);
            end else if (timeout_s || ((state_r == S_IDLE) && mis_trap_s)) begin
                rdata <= 32'd0;
            end else begin
                rdata <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; a second instance with a short
// timeout and a never-ready bus exercises the abort path.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_write, mem_read, mem_write_t, mem_read_t;
    logic [1:0]  store;
    logic [2:0]  load;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_ready, ready_t;

    logic [31:0] rdata, mem_addr, mem_wdata, rdata_t, mem_addr_t, mem_wdata_t;
    logic        stall, misalign, bus_err, mem_req, mem_we;
    logic        stall_t, misalign_t, bus_err_t, mem_req_t, mem_we_t;
    logic [3:0]  mem_wstrb, mem_wstrb_t;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset_n(reset_n), .mem_write(mem_write), .mem_read(mem_read),
        .store(store), .load(load), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_t (
        .clk(clk), .reset_n(reset_n), .mem_write(mem_write_t), .mem_read(mem_read_t),
        .store(store), .load(load), .addr(addr), .wdata(wdata), .rdata(rdata_t),
        .stall(stall_t), .misalign(misalign_t), .bus_err(bus_err_t), .mem_req(mem_req_t),
        .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_wstrb(mem_wstrb_t),
        .mem_wdata(mem_wdata_t), .mem_rdata(mem_rdata), .mem_ready(ready_t)
    );

    // Drives one access, answers mem_ready after dly REQ cycles, and reports what it saw.
    task automatic access(input logic we_i, input logic rd_i, input logic [1:0] st_i,
                          input logic [2:0] ld_i, input logic [31:0] a_i,
                          input logic [31:0] wd_i, input int dly, input logic use_t,
                          output int n_stall, output int n_req,
                          output logic [31:0] o_addr, output logic [31:0] o_wdata,
                          output logic [3:0] o_strb, output logic o_we,
                          output logic [31:0] o_rdata, output logic o_err,
                          output logic o_mis, output logic done);
        logic s, r;
        @(negedge clk);
        if (use_t) begin
            mem_write_t = we_i; mem_read_t = rd_i;
        end else begin
            mem_write = we_i; mem_read = rd_i;
        end
        store = st_i; load = ld_i; addr = a_i; wdata = wd_i; mem_ready = 1'b0;
        n_stall = 0; n_req = 0; done = 1'b0;
        o_addr = 32'hx; o_wdata = 32'hx; o_strb = 4'hx; o_we = 1'bx;
        o_rdata = 32'hx; o_err = 1'bx; o_mis = 1'bx;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            s = use_t ? stall_t : stall;
            r = use_t ? mem_req_t : mem_req;
            if (s) n_stall++;
            if (r) begin
                n_req++;
                if (n_req == 1) begin
                    o_addr  = use_t ? mem_addr_t : mem_addr;
                    o_wdata = use_t ? mem_wdata_t : mem_wdata;
                    o_strb  = use_t ? mem_wstrb_t : mem_wstrb;
                    o_we    = use_t ? mem_we_t : mem_we;
                end
            end
            if (!s && c > 0) begin
                done    = 1'b1;
                o_rdata = use_t ? rdata_t : rdata;
                o_err   = use_t ? bus_err_t : bus_err;
                o_mis   = use_t ? misalign_t : misalign;
                mem_write = 1'b0; mem_read = 1'b0;
                mem_write_t = 1'b0; mem_read_t = 1'b0;
                mem_ready = 1'b0;
            end else begin
                mem_ready = (n_req > dly);
                @(negedge clk);
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL access_timeout: no completion within budget, addr=%h", a_i);
            mem_write = 1'b0; mem_read = 1'b0; mem_write_t = 1'b0; mem_read_t = 1'b0;
            mem_ready = 1'b0;
        end
    endtask

    int          ns, nr;
    logic [31:0] oa, ow, orr;
    logic [3:0]  ob;
    logic        owe, oe, om, od;

    task automatic test_reset();
        reset_n = 1'b0; mem_write = 1'b1; mem_read = 1'b0; mem_write_t = 1'b0;
        mem_read_t = 1'b0; store = 2'b10; load = 3'b010; addr = 32'h0; wdata = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0; ready_t = 1'b0;
        #22;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wstrb !== 4'h0) begin n_bad++; $display("FAIL rst_strb: got %h want 0", mem_wstrb); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL rst_mis: got %b want 0", misalign); end
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus_err); end
        mem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store();
        access(1'b1, 1'b0, 2'b10, 3'b010, 32'h104, 32'hDEADBEEF, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (oa !== 32'h104) begin n_bad++; $display("FAIL sw_addr: got %h want 00000104", oa); end
        n_cmp++; if (ob !== 4'b1111) begin n_bad++; $display("FAIL sw_strb: got %b want 1111", ob); end
        n_cmp++; if (owe !== 1'b1) begin n_bad++; $display("FAIL sw_we: got %b want 1", owe); end
        n_cmp++; if (ow !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", ow); end
        n_cmp++; if (ns != 2) begin n_bad++; $display("FAIL sw_stall: got %0d want 2", ns); end
        n_cmp++; if (nr != 1) begin n_bad++; $display("FAIL sw_req: got %0d want 1", nr); end
        access(1'b1, 1'b0, 2'b00, 3'b010, 32'h203, 32'h000000A5, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (oa !== 32'h200) begin n_bad++; $display("FAIL sb_addr: got %h want 00000200", oa); end
        n_cmp++; if (ob !== 4'b1000) begin n_bad++; $display("FAIL sb_strb: got %b want 1000", ob); end
        n_cmp++; if (ow !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", ow); end
        access(1'b1, 1'b0, 2'b01, 3'b010, 32'h202, 32'h1234ABCD, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (ob !== 4'b1100) begin n_bad++; $display("FAIL sh_strb: got %b want 1100", ob); end
        n_cmp++; if (ow !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", ow); end
    endtask

    task automatic test_load_ext();
        mem_rdata = 32'h1280FF34;
        access(1'b0, 1'b1, 2'b00, 3'b000, 32'h302, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (orr !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_302: got %h want ffffff80", orr); end
        n_cmp++; if (ob !== 4'b1111 || owe !== 1'b0) begin n_bad++; $display("FAIL lb_strb_we: got %b/%b want 1111/0", ob, owe); end
        access(1'b0, 1'b1, 2'b00, 3'b100, 32'h302, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (orr !== 32'h00000080) begin n_bad++; $display("FAIL lbu_302: got %h want 00000080", orr); end
        access(1'b0, 1'b1, 2'b00, 3'b001, 32'h302, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (orr !== 32'h00001280) begin n_bad++; $display("FAIL lh_302: got %h want 00001280", orr); end
        access(1'b0, 1'b1, 2'b00, 3'b001, 32'h300, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (orr !== 32'hFFFFFF34) begin n_bad++; $display("FAIL lh_300: got %h want ffffff34", orr); end
        access(1'b0, 1'b1, 2'b00, 3'b101, 32'h300, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (orr !== 32'h0000FF34) begin n_bad++; $display("FAIL lhu_300: got %h want 0000ff34", orr); end
        access(1'b0, 1'b1, 2'b00, 3'b000, 32'h301, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (orr !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL lb_301: got %h want ffffffff", orr); end
    endtask

    task automatic test_wait_states();
        mem_rdata = 32'hCAFEF00D;
        access(1'b0, 1'b1, 2'b00, 3'b010, 32'h400, 32'h0, 5, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (nr != 6) begin n_bad++; $display("FAIL lw_wait_req: got %0d want 6", nr); end
        n_cmp++; if (ns != 7) begin n_bad++; $display("FAIL lw_wait_stall: got %0d want 7", ns); end
        n_cmp++; if (orr !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lw_wait_rdata: got %h want cafef00d", orr); end
        n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL lw_wait_err: got %b want 0", oe); end
    endtask

    task automatic test_timeout();
        mem_rdata = 32'h55AA55AA;
        access(1'b0, 1'b1, 2'b00, 3'b010, 32'h500, 32'h0, 1000, 1'b1, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (nr != 4) begin n_bad++; $display("FAIL to_req: got %0d want 4", nr); end
        n_cmp++; if (ns != 5) begin n_bad++; $display("FAIL to_stall: got %0d want 5", ns); end
        n_cmp++; if (oe !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", oe); end
        n_cmp++; if (orr !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h want 0", orr); end
        @(negedge clk); #1;
        n_cmp++; if (bus_err_t !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", bus_err_t); end
        n_cmp++; if (mem_req_t !== 1'b0 || stall_t !== 1'b0) begin n_bad++; $display("FAIL to_idle: got req=%b stall=%b want 0/0", mem_req_t, stall_t); end
    endtask

    task automatic test_misalign();
        mem_rdata = 32'h87654321;
        access(1'b0, 1'b1, 2'b00, 3'b010, 32'h101, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
`ifdef MISALIGN_TRAP_EN
        n_cmp++; if (nr != 0) begin n_bad++; $display("FAIL mis_lw_req: got %0d want 0", nr); end
        n_cmp++; if (om !== 1'b1) begin n_bad++; $display("FAIL mis_lw_flag: got %b want 1", om); end
        n_cmp++; if (orr !== 32'h0) begin n_bad++; $display("FAIL mis_lw_rdata: got %h want 0", orr); end
        n_cmp++; if (ns != 1) begin n_bad++; $display("FAIL mis_lw_stall: got %0d want 1", ns); end
        access(1'b1, 1'b0, 2'b01, 3'b010, 32'h203, 32'h5678, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (nr != 0 || om !== 1'b1) begin n_bad++; $display("FAIL mis_sh: got req=%0d mis=%b want 0/1", nr, om); end
`else
        n_cmp++; if (oa !== 32'h100) begin n_bad++; $display("FAIL mis_lw_addr: got %h want 00000100", oa); end
        n_cmp++; if (om !== 1'b0) begin n_bad++; $display("FAIL mis_lw_flag: got %b want 0", om); end
        n_cmp++; if (orr !== 32'h87654321) begin n_bad++; $display("FAIL mis_lw_rdata: got %h want 87654321", orr); end
        access(1'b1, 1'b0, 2'b01, 3'b010, 32'h203, 32'h5678, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (ob !== 4'b1100 || oa !== 32'h200) begin n_bad++; $display("FAIL mis_sh: got strb=%b addr=%h want 1100/00000200", ob, oa); end
        n_cmp++; if (ow !== 32'h56785678) begin n_bad++; $display("FAIL mis_sh_wdata: got %h want 56785678", ow); end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_read = 1'b1; load = 3'b010; addr = 32'h600; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rm_req_before: got %b want 1", mem_req); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_drop: got %b want 0", mem_req); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rm_stall: got %b want 0", stall); end
        mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rm_idle: got req=%b stall=%b want 0/0", mem_req, stall); end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 1'b0, 2'b10, 3'b010, 32'h700, 32'h11223344, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (oa !== 32'h700 || ow !== 32'h11223344) begin n_bad++; $display("FAIL b2b_st: got %h/%h want 00000700/11223344", oa, ow); end
        mem_rdata = 32'hAB000000;
        access(1'b0, 1'b1, 2'b00, 3'b100, 32'h703, 32'h0, 0, 1'b0, ns, nr, oa, ow, ob, owe, orr, oe, om, od);
        n_cmp++; if (ns != 2) begin n_bad++; $display("FAIL b2b_stall: got %0d want 2", ns); end
        n_cmp++; if (orr !== 32'h000000AB) begin n_bad++; $display("FAIL b2b_lbu: got %h want 000000ab", orr); end
        n_cmp++; if (owe !== 1'b0 || oa !== 32'h700) begin n_bad++; $display("FAIL b2b_ld_bus: got we=%b addr=%h want 0/00000700", owe, oa); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_ext();
        test_wait_states();
        test_timeout();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
